// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the configuration-domain sequencer: state encoding,
// frame-format constants and header field positions.
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StHdr2,
    StData,
    StSkip,
    StDone
  } cfg_state_e;

  localparam logic [7:0]  CFG_TERMINATOR = 8'hFF;
  localparam int unsigned CFG_ADDR_W     = 10;
  localparam int unsigned CFG_DATA_W     = 8;

  // H2 = {len[5:0], addr[9:8]}
  localparam int unsigned CFG_H2_LEN_MSB = 7;
  localparam int unsigned CFG_H2_LEN_LSB = 2;
  localparam int unsigned CFG_H2_AHI_MSB = 1;
  localparam int unsigned CFG_H2_AHI_LSB = 0;

  localparam int unsigned CFG_MAX_LEN    = 64;
  localparam int unsigned CFG_LEN_W      = $clog2(CFG_MAX_LEN);

endpackage

// File: rtl/tile_config_sequencer.sv
// Parses a byte stream of configuration frames into one-hot tile write cycles with
// address auto-increment, invalid-tile frame skipping, and sticky status.
module tile_config_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned N_TILES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  conf,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CFG_DATA_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_TILES-1:0]    select_tile,
  output logic [CFG_ADDR_W-1:0] address_tile,
  output logic [CFG_DATA_W-1:0] data_tile,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      wr_count
);

  localparam int unsigned IdW = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  cfg_state_e            state_q, state_d;
  logic [IdW-1:0]        id_q, id_d;
  logic                  ok_q, ok_d;
  logic [CFG_ADDR_W-1:0] addr_q, addr_d;
  logic [CFG_LEN_W-1:0]  len_q, len_d;
  logic [N_TILES-1:0]    sel_q, sel_d;
  logic [CFG_ADDR_W-1:0] aout_q, aout_d;
  logic [CFG_DATA_W-1:0] dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  active;
  logic                  accept;

  assign active = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StHdr2) ||
                  (state_q == StData) || (state_q == StSkip);
  assign accept = in_valid && active;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ok_d    = ok_q;
    addr_d  = addr_q;
    len_d   = len_q;
    sel_d   = '0;
    aout_d  = '0;
    dout_d  = '0;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StHdr0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StHdr0: begin
        if (accept) begin
          if (in_data == CFG_TERMINATOR) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (32'(in_data) < N_TILES) begin
            id_d    = in_data[IdW-1:0];
            ok_d    = 1'b1;
            state_d = StHdr1;
          end else begin
            ok_d    = 1'b0;
            err_d   = 1'b1;
            state_d = StHdr1;
          end
        end
      end
      StHdr1: begin
        if (accept) begin
          addr_d[7:0] = in_data;
          state_d     = StHdr2;
        end
      end
      StHdr2: begin
        if (accept) begin
          addr_d[CFG_ADDR_W-1:8] = in_data[CFG_H2_AHI_MSB:CFG_H2_AHI_LSB];
          len_d   = in_data[CFG_H2_LEN_MSB:CFG_H2_LEN_LSB];
          state_d = ok_q ? StData : StSkip;
        end
      end
      StData, StSkip: begin
        if (accept) begin
          if (state_q == StData) begin
            sel_d[id_q] = 1'b1;
            aout_d      = addr_q;
            dout_d      = in_data;
            addr_d      = addr_q + 1'b1;  // natural 10-bit wrap
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end
          len_d = len_q - 1'b1;
          if (len_q == '0) state_d = StHdr0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge conf) begin
    if (reset) begin
      state_q <= StIdle;
      id_q    <= '0;
      ok_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      aout_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ok_q    <= ok_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      aout_q  <= aout_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = active;
  assign busy         = active;
  assign select_tile  = sel_q;
  assign address_tile = aout_q;
  assign data_tile    = dout_q;
  assign done         = done_q;
  assign err          = err_q;
  assign wr_count     = cnt_q;

endmodule

// File: tb/tb_tile_config_sequencer.sv
// Bench for tile_config_sequencer: frames are expanded into a per-byte expectation
// queue (which byte writes where) and every cycle is compared against that model.
module tb_tile_config_sequencer;

  localparam int unsigned NT = 16;
  localparam int unsigned CW = 16;

  logic          conf = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NT-1:0] select_tile;
  logic [9:0]    address_tile;
  logic [7:0]    data_tile;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] wr_count;

  tile_config_sequencer #(
    .N_TILES(NT),
    .CNT_W  (CW)
  ) dut (
    .conf        (conf),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .select_tile (select_tile),
    .address_tile(address_tile),
    .data_tile   (data_tile),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .wr_count    (wr_count)
  );

  always #5 conf = ~conf;

  // One entry per stream byte, annotated with the write it must cause (if any).
  typedef struct {
    logic [7:0] b;
    bit         wr;
    int         tile;
    int         addr;
    logic [7:0] d;
    bit         term;
    bit         bad;
  } ent_t;

  ent_t       q[$];
  logic [7:0] dbuf[64];
  int         vectors = 0;
  int         miscompares = 0;
  bit         m_active = 0;
  bit         m_done = 0;
  bit         m_err = 0;
  int         m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  function automatic ent_t mk(input logic [7:0] b);
    ent_t e;
    e.b = b; e.wr = 0; e.tile = 0; e.addr = 0; e.d = 8'h00; e.term = 0; e.bad = 0;
    return e;
  endfunction

  task automatic push_frame(input int id, input int addr, input int len);
    ent_t e;
    e = mk(8'(id));
    e.bad = (id >= int'(NT));
    q.push_back(e);
    q.push_back(mk(8'(addr)));
    q.push_back(mk({6'(len), 2'(addr >> 8)}));
    for (int i = 0; i <= len; i++) begin
      e = mk(dbuf[i]);
      if (id < int'(NT)) begin
        e.wr = 1; e.tile = id; e.addr = (addr + i) % 1024; e.d = dbuf[i];
      end
      q.push_back(e);
    end
  endtask

  task automatic push_term();
    ent_t e;
    e = mk(8'hFF);
    e.term = 1;
    q.push_back(e);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) dbuf[i] = 8'($urandom);
  endtask

  task automatic step(input bit vreq, input bit st);
    ent_t          e;
    bit            acc;
    logic [NT-1:0] es;
    logic [9:0]    ea;
    logic [7:0]    ed;
    @(negedge conf);
    start    = st;
    in_valid = vreq && (q.size() > 0);
    in_data  = in_valid ? q[0].b : 8'($urandom);
    check("in_ready", 64'(in_ready), 64'(m_active));
    acc = in_valid && m_active;
    @(posedge conf);
    #1;
    es = '0; ea = '0; ed = '0;
    if (st && !m_active) begin
      m_active = 1; m_done = 0; m_err = 0; m_cnt = 0;
    end else if (acc) begin
      e = q.pop_front();
      if (e.wr) begin
        es[e.tile] = 1'b1;
        ea = 10'(e.addr);
        ed = e.d;
        if (m_cnt < 65535) m_cnt++;
      end
      if (e.bad) m_err = 1;
      if (e.term) begin
        m_done = 1; m_active = 0;
      end
    end
    check("select_tile", 64'(select_tile), 64'(es));
    check("address_tile", 64'(address_tile), 64'(ea));
    check("data_tile", 64'(data_tile), 64'(ed));
    check("busy", 64'(busy), 64'(m_active));
    check("done", 64'(done), 64'(m_done));
    check("err", 64'(err), 64'(m_err));
    check("wr_count", 64'(wr_count), 64'(m_cnt));
  endtask

  task automatic drain(input bit rand_valid);
    int budget = 0;
    while (q.size() > 0 && budget < 5000) begin
      step(rand_valid ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      budget++;
    end
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge conf);
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(posedge conf);
    #1;
    q.delete();
    m_active = 0; m_done = 0; m_err = 0; m_cnt = 0;
    check("rst_select", 64'(select_tile), 64'd0);
    check("rst_address", 64'(address_tile), 64'd0);
    check("rst_data", 64'(data_tile), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    @(negedge conf);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge conf);
    do_reset();

    // Directed frame; start coincides with a valid byte that must not be taken
    dbuf[0] = 8'hA0;
    dbuf[1] = 8'hA1;
    push_frame(3, 'h210, 1);
    step(1'b1, 1'b1);
    drain(1'b0);
    check("wr_count_first_frame", 64'(wr_count), 64'd2);

    // Address wrap from 0x3FF to 0x000
    dbuf[0] = 8'h11;
    dbuf[1] = 8'h22;
    push_frame(1, 'h3FF, 1);
    drain(1'b0);

    // Invalid tile id: bytes consumed silently, err set; start mid-session ignored
    fill_random();
    push_frame('h20, 'h055, 2);
    step(1'b1, 1'b1);
    drain(1'b0);
    fill_random();
    push_frame(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 1023)), 3);
    drain(1'b0);

    // Back-to-back frames and terminator with in_valid held high
    fill_random();
    push_frame(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 7)));
    fill_random();
    push_frame(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 7)));
    push_term();
    drain(1'b0);
    q.push_back(mk(8'h03));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("after_done_pending", 64'(q.size()), 64'd1);
    q.delete();

    // Reset in the middle of the data phase, then recover
    step(1'b0, 1'b1);
    fill_random();
    push_frame(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 1023)), 5);
    repeat (5) step(1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b1);
    fill_random();
    push_frame(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 1023)), 2);
    drain(1'b0);

    // Maximum-length frame with randomly gapped in_valid
    fill_random();
    push_frame(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 1023)), 63);
    drain(1'b1);
    check("wr_count_max_frame", 64'(wr_count), 64'd67);
    for (int f = 0; f < 4; f++) begin
      fill_random();
      push_frame(int'($urandom_range(0, 20)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 15)));
    end
    push_term();
    drain(1'b1);
    check("final_done", 64'(done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
